prbs9_symbol_gen: RTL

//   Dual-channel (I/Q) PRBS9 reference source for the TX filter chain. Emits one bit per channel every
//   OS_FACTOR enabled clocks with a one-cycle o_valid strobe. Drives the TX shaping filter and also

---
 rtl/prbs9_symbol_gen_pkg.sv | 29 ++
 rtl/prbs9_lfsr.sv | 29 ++
 rtl/prbs9_symbol_gen.sv | 112 +++++++++++
 3 files changed

// File: rtl/prbs9_symbol_gen_pkg.sv
// Shared constants, helpers and output bundle for the PRBS9 I/Q symbol source.
// Used by prbs9_lfsr and prbs9_symbol_gen (optional feature macro: PRBS_ERR_INJ_EN).
package prbs9_symbol_gen_pkg;

   localparam int PRBS9_LEN    = 9;
   localparam int PRBS9_TAP_HI = 8;
   localparam int PRBS9_TAP_LO = 4;
   localparam int PRBS9_PERIOD = 511;

   localparam logic [PRBS9_LEN-1:0] PRBS9_NONZERO_SEED = 9'h001;

   // An all-zero LFSR would lock up, so a zero seed is replaced with a legal one.
   function automatic logic [PRBS9_LEN-1:0] prbs9_legal_seed(input logic [PRBS9_LEN-1:0] seed);
      return (seed == '0) ? PRBS9_NONZERO_SEED : seed;
   endfunction

   function automatic logic [PRBS9_LEN-1:0] prbs9_next(input logic [PRBS9_LEN-1:0] state);
      return {state[PRBS9_LEN-2:0], state[PRBS9_TAP_HI] ^ state[PRBS9_TAP_LO]};
   endfunction

   typedef struct packed {
      logic                 valid;
      logic                 period_start;
      logic                 data_i;
      logic                 data_q;
      logic [PRBS9_LEN-1:0] symbol_count;
   } prbs9_sym_t;

endpackage

// File: rtl/prbs9_lfsr.sv
// Single PRBS9 (x^9+x^5+1) generator: loads its seed on reset or i_load, steps on i_step.
// o_bit is the current (pre-shift) MSB.
module prbs9_lfsr
   import prbs9_symbol_gen_pkg::*;
#(
   parameter logic [PRBS9_LEN-1:0] SEED = 9'h001
) (
   input  logic clock,
   input  logic i_reset,
   input  logic i_load,
   input  logic i_step,
   output logic o_bit
);

   localparam logic [PRBS9_LEN-1:0] LP_SEED = prbs9_legal_seed(SEED);

   logic [PRBS9_LEN-1:0] r_lfsr;

   always_ff @(posedge clock) begin
      if (i_reset || i_load) begin
         r_lfsr <= LP_SEED;
      end else if (i_step) begin
         r_lfsr <= prbs9_next(r_lfsr);
      end
   end

   assign o_bit = r_lfsr[PRBS9_TAP_HI];

endmodule

// File: rtl/prbs9_symbol_gen.sv
// Dual-channel PRBS9 symbol source with oversampling phase counter, symbol index and period marker.
// Optional error injection on the I channel when PRBS_ERR_INJ_EN is defined.
module prbs9_symbol_gen
   import prbs9_symbol_gen_pkg::*;
#(
   parameter logic [PRBS9_LEN-1:0] SEED_I    = 9'h1AA,
   parameter logic [PRBS9_LEN-1:0] SEED_Q    = 9'h1FE,
   parameter int                   OS_FACTOR = 4
) (
   input  logic                 clock,
   input  logic                 i_reset,
   input  logic                 i_enable,
   input  logic                 i_restart,
`ifdef PRBS_ERR_INJ_EN
   input  logic                 i_err_inject,
   output logic [15:0]          o_err_count,
`endif
   output logic                 o_data_prbsI,
   output logic                 o_data_prbsQ,
   output logic                 o_valid,
   output logic                 o_period_start,
   output logic [PRBS9_LEN-1:0] o_symbol_count
);

   localparam logic [7:0]           LP_PHASE_LAST = 8'(OS_FACTOR - 1);
   localparam logic [PRBS9_LEN-1:0] LP_IDX_LAST   = PRBS9_LEN'(PRBS9_PERIOD - 1);

   logic [7:0]           r_phase;
   logic [PRBS9_LEN-1:0] r_sym_idx;
   prbs9_sym_t           r_out;

   logic w_advance;
   logic w_bit_i;
   logic w_bit_q;
   logic w_data_i;

   assign w_advance = i_enable && (r_phase == LP_PHASE_LAST);

   // Restart outranks the step inside the LFSR, so a restart on an advance cycle re-seeds cleanly.
   prbs9_lfsr #(.SEED(SEED_I)) u_lfsr_i (
      .clock   (clock),
      .i_reset (i_reset),
      .i_load  (i_restart),
      .i_step  (w_advance),
      .o_bit   (w_bit_i)
   );

   prbs9_lfsr #(.SEED(SEED_Q)) u_lfsr_q (
      .clock   (clock),
      .i_reset (i_reset),
      .i_load  (i_restart),
      .i_step  (w_advance),
      .o_bit   (w_bit_q)
   );

`ifdef PRBS_ERR_INJ_EN
   assign w_data_i = w_bit_i ^ i_err_inject;
`else
   assign w_data_i = w_bit_i;
`endif

   always_ff @(posedge clock) begin
      if (i_reset) begin
         r_phase   <= '0;
         r_sym_idx <= '0;
         r_out     <= '0;
      end else if (i_restart) begin
         r_phase            <= '0;
         r_sym_idx          <= '0;
         r_out.valid        <= 1'b0;
         r_out.period_start <= 1'b0;
      end else if (i_enable) begin
         if (r_phase == LP_PHASE_LAST) begin
            r_phase            <= '0;
            r_out.valid        <= 1'b1;
            r_out.period_start <= (r_sym_idx == '0);
            r_out.data_i       <= w_data_i;
            r_out.data_q       <= w_bit_q;
            r_out.symbol_count <= r_sym_idx;
            r_sym_idx          <= (r_sym_idx == LP_IDX_LAST) ? '0 : PRBS9_LEN'(r_sym_idx + 1'b1);
         end else begin
            r_phase            <= 8'(r_phase + 1'b1);
            r_out.valid        <= 1'b0;
            r_out.period_start <= 1'b0;
         end
      end else begin
         r_out.valid        <= 1'b0;
         r_out.period_start <= 1'b0;
      end
   end

`ifdef PRBS_ERR_INJ_EN
   logic [15:0] r_err_count;

   always_ff @(posedge clock) begin
      if (i_reset || i_restart) begin
         r_err_count <= '0;
      end else if (w_advance && i_err_inject && (r_err_count != 16'hFFFF)) begin
         r_err_count <= 16'(r_err_count + 1'b1);
      end
   end

   assign o_err_count = r_err_count;
`endif

   assign o_data_prbsI   = r_out.data_i;
   assign o_data_prbsQ   = r_out.data_q;
   assign o_valid        = r_out.valid;
   assign o_period_start = r_out.period_start;
   assign o_symbol_count = r_out.symbol_count;

endmodule
